// File: rtl/uart_alu_if.sv
// Bridges a UART FIFO pair to a combinational ALU: three received bytes (A, B, opcode) yield one result byte.
// Optional inter-byte timeout is enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int DBIT           = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            timeout_err
);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND} state_t;

  state_t          r_state, w_next;
  logic            w_rd, w_wr, w_tmo, w_tmo_hit;
  logic [DBIT-1:0] r_a, r_b, r_wdata;
  logic [OP_W-1:0] r_op;

`ifdef UART_IF_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = ((r_state == WAIT_B) || (r_state == WAIT_OP)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Gap counter only runs while a frame is partially received.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_tmo_cnt <= '0;
    else if (w_rd || (w_next == WAIT_A)) r_tmo_cnt <= '0;
    else if ((r_state == WAIT_B) || (r_state == WAIT_OP))
                                         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      WAIT_A:  if (!rx_empty) begin w_rd = 1'b1; w_next = WAIT_B; end
      WAIT_B, WAIT_OP: begin
        // Timeout wins over a byte arriving in the same cycle; that byte stays queued.
        if (w_tmo_hit) begin
          w_tmo  = 1'b1;
          w_next = WAIT_A;
        end else if (!rx_empty) begin
          w_rd   = 1'b1;
          w_next = (r_state == WAIT_B) ? WAIT_OP : EXEC;
        end
      end
      EXEC:    w_next = SEND;
      SEND:    if (!tx_full) begin w_wr = 1'b1; w_next = WAIT_A; end
      default: w_next = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd) begin
        case (r_state)
          WAIT_A:  r_a  <= r_data;
          WAIT_B:  r_b  <= r_data;
          WAIT_OP: r_op <= r_data[OP_W-1:0];
          default: ;
        endcase
      end
      if (r_state == EXEC) r_wdata <= alu_result;
    end
  end

  // Strobes are gated by reset so they read 0 the instant reset asserts.
  assign rd_uart     = w_rd  & reset;
  assign wr_uart     = w_wr  & reset;
  assign timeout_err = w_tmo & reset;
  assign w_data      = r_wdata;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_op      = r_op;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if: FIFO model on the rx side, logger on the tx side, small ALU model.
module tb_uart_alu_if;
  localparam int DBIT = 8;
  localparam int OP_W = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full = 1'b0;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [DBIT-1:0] alu_a, alu_b;
  logic [OP_W-1:0] alu_op;
  logic [DBIT-1:0] alu_result;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  uart_alu_if #(.DBIT(DBIT), .OP_W(OP_W), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  // rx FIFO model
  logic [DBIT-1:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign rx_empty = (rp == wp);
  assign r_data   = mem[rp % 64];

  // Event log
  int cyc = 0, pop_cnt = 0, tx_cnt = 0, tmo_cnt = 0, bad_pop = 0, tmo_cyc = 0;
  int pop_cyc [0:63];
  int tx_cyc  [0:63];
  logic [DBIT-1:0] tx_data [0:63];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin
      pop_cyc[pop_cnt] <= cyc;
      pop_cnt <= pop_cnt + 1;
      rp <= rp + 1;
      if (rx_empty) bad_pop <= bad_pop + 1;
    end
    if (wr_uart) begin
      tx_data[tx_cnt] <= w_data;
      tx_cyc[tx_cnt]  <= cyc;
      tx_cnt <= tx_cnt + 1;
    end
    if (timeout_err) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_cyc <= cyc;
    end
  end

  task automatic push(input logic [DBIT-1:0] b);
    mem[wp % 64] = b;
    wp = wp + 1;
  endtask

  task automatic wait_pop(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pop_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    push(8'hAA);
    #1;
    checks++;
    if ({rd_uart, wr_uart, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b exp 000", {rd_uart, wr_uart, timeout_err});
    end
    checks++;
    if ({w_data, alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL reset_regs got %h %h %h %h exp 0", w_data, alu_a, alu_b, alu_op);
    end
    repeat (3) @(negedge clk);
    wp = rp;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int pb, tb0;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt;
    push(8'h05); push(8'h03); push(8'h20);
    wait_tx(tb0 + 1, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_tx_timeout got none exp 1 pulse"); end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++; $display("FAIL basic_operands got %h %h %h exp 05 03 20", alu_a, alu_b, alu_op);
    end
    checks++;
    if (tx_data[tb0] !== 8'h08) begin
      errors++; $display("FAIL basic_result got %h exp 08", tx_data[tb0]);
    end
    checks++;
    if (tx_cyc[tb0] - pop_cyc[pb + 2] !== 2) begin
      errors++; $display("FAIL basic_latency got %0d exp 2", tx_cyc[tb0] - pop_cyc[pb + 2]);
    end
    checks++;
    if (pop_cyc[pb + 1] - pop_cyc[pb] !== 1 || pop_cyc[pb + 2] - pop_cyc[pb + 1] !== 1) begin
      errors++; $display("FAIL basic_b2b_pops got %0d %0d exp 1 1",
                         pop_cyc[pb + 1] - pop_cyc[pb], pop_cyc[pb + 2] - pop_cyc[pb + 1]);
    end
    checks++;
    if (tx_cnt !== tb0 + 1) begin
      errors++; $display("FAIL basic_tx_count got %0d exp %0d", tx_cnt, tb0 + 1);
    end
  endtask

  task automatic test_hold;
    int pb, tb0;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt;
    push(8'h7E);
    wait_pop(pb + 1, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (pop_cnt !== pb + 1 || tx_cnt !== tb0) begin
      errors++; $display("FAIL hold_idle got pops %0d tx %0d exp %0d %0d", pop_cnt, tx_cnt, pb + 1, tb0);
    end
    checks++;
    if ({alu_a, alu_b} !== {8'h7E, 8'h03}) begin
      errors++; $display("FAIL hold_operands got %h %h exp 7e 03", alu_a, alu_b);
    end
    push(8'h01); push(8'h20);
    wait_tx(tb0 + 1, ok);
    @(negedge clk);
    checks++;
    if (!ok || tx_data[tb0] !== 8'h7F) begin
      errors++; $display("FAIL hold_result got %h exp 7f", tx_data[tb0]);
    end
  endtask

  task automatic test_backpressure;
    int pb, tb0, bad;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt; bad = 0;
    tx_full = 1'b1;
    push(8'h05); push(8'h03); push(8'h20);
    wait_pop(pb + 3, ok);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (wr_uart !== 1'b0 || w_data !== 8'h08) bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad != 0 || tx_cnt !== tb0) begin
      errors++; $display("FAIL bp_stall got bad %0d tx %0d exp 0 %0d", bad, tx_cnt, tb0);
    end
    tx_full = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (tx_cnt !== tb0 + 1 || tx_data[tb0] !== 8'h08) begin
      errors++; $display("FAIL bp_release got cnt %0d data %h exp %0d 08", tx_cnt, tx_data[tb0], tb0 + 1);
    end
  endtask

  task automatic test_back_to_back;
    int pb, tb0;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt;
    push(8'h0A); push(8'h02); push(8'h22);
    push(8'hF0); push(8'h0F); push(8'h24);
    wait_tx(tb0 + 2, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || tx_cnt !== tb0 + 2 || tx_data[tb0] !== 8'h08 || tx_data[tb0 + 1] !== 8'h00) begin
      errors++; $display("FAIL b2b_results got cnt %0d %h %h exp %0d 08 00",
                         tx_cnt, tx_data[tb0], tx_data[tb0 + 1], tb0 + 2);
    end
    checks++;
    if (pop_cyc[pb + 3] - pop_cyc[pb + 2] !== 3) begin
      errors++; $display("FAIL b2b_no_pop_exec_send got gap %0d exp 3", pop_cyc[pb + 3] - pop_cyc[pb + 2]);
    end
  endtask

  task automatic test_timeout;
    int pb, tb0, tm0;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt; tm0 = tmo_cnt;
    push(8'h11);
    wait_pop(pb + 1, ok);
    repeat (120) @(negedge clk);
    checks++;
    if (alu_a !== 8'h11 || pop_cnt !== pb + 1) begin
      errors++; $display("FAIL tmo_capture got %h pops %0d exp 11 %0d", alu_a, pop_cnt, pb + 1);
    end
`ifdef UART_IF_TIMEOUT_EN
    checks++;
    if (tmo_cnt !== tm0 + 1 || tmo_cyc - pop_cyc[pb] !== 100) begin
      errors++; $display("FAIL tmo_pulse got cnt %0d delay %0d exp %0d 100",
                         tmo_cnt, tmo_cyc - pop_cyc[pb], tm0 + 1);
    end
    push(8'h01); push(8'h01); push(8'h20);
    wait_tx(tb0 + 1, ok);
    @(negedge clk);
    checks++;
    if (!ok || tx_data[tb0] !== 8'h02) begin
      errors++; $display("FAIL tmo_recover got %h exp 02", tx_data[tb0]);
    end
`else
    checks++;
    if (tmo_cnt !== tm0) begin
      errors++; $display("FAIL tmo_disabled got %0d exp %0d", tmo_cnt, tm0);
    end
    push(8'h01); push(8'h20);
    wait_tx(tb0 + 1, ok);
    @(negedge clk);
    checks++;
    if (!ok || tx_data[tb0] !== 8'h12) begin
      errors++; $display("FAIL tmo_resume got %h exp 12", tx_data[tb0]);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int pb, tb0;
    bit ok;
    pb = pop_cnt; tb0 = tx_cnt;
    push(8'h33); push(8'h44);
    wait_pop(pb + 2, ok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!ok || {rd_uart, wr_uart, timeout_err, w_data, alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL rstmid_async got %h %h %h %h exp 0", w_data, alu_a, alu_b, alu_op);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_cnt !== tb0) begin
      errors++; $display("FAIL rstmid_no_tx got %0d exp %0d", tx_cnt, tb0);
    end
    push(8'h02); push(8'h02); push(8'h20);
    wait_tx(tb0 + 1, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || tx_cnt !== tb0 + 1 || tx_data[tb0] !== 8'h04) begin
      errors++; $display("FAIL rstmid_frame got cnt %0d data %h exp %0d 04", tx_cnt, tx_data[tb0], tb0 + 1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_backpressure;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    checks++;
    if (bad_pop !== 0) begin
      errors++; $display("FAIL pop_when_empty got %0d exp 0", bad_pop);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_if.md
UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
REQ-001 Parameter: DBIT, 8, width of data bytes and ALU operands/result.
REQ-002 Parameter: OP_W, 6, ALU opcode width, taken from the DBIT-wide opcode byte's low OP_W bits.
REQ-003 Parameter: TIMEOUT_CYCLES, 65535, inter-byte gap limit in clk cycles (used only with UART_IF_TIMEOUT_EN).
REQ-004 Port: clk  in  1  single system clock, all logic on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: rx_empty  in  1  UART receive FIFO empty flag.
REQ-007 Port: r_data  in  DBIT  UART receive FIFO head byte, valid while rx_empty=0.
REQ-008 Port: rd_uart  out  1  one-cycle pop strobe to receive FIFO.
REQ-009 Port: tx_full  in  1  UART transmit FIFO full flag.
REQ-010 Port: wr_uart  out  1  one-cycle push strobe to transmit FIFO.
REQ-011 Port: w_data  out  DBIT  byte pushed with wr_uart.
REQ-012 Port: alu_a, alu_b  out  DBIT each  registered operand A, operand B.
REQ-013 Port: alu_op  out  OP_W  registered opcode.
REQ-014 Port: alu_result  in  DBIT  combinational ALU result of alu_a/alu_b/alu_op.
REQ-015 Port: timeout_err  out  1  one-cycle pulse on aborted frame; constant 0 without UART_IF_TIMEOUT_EN.

Function
REQ-016 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND; reset state WAIT_A.
REQ-017 In WAIT_A/WAIT_B/WAIT_OP with rx_empty=0: capture r_data into alu_a/alu_b/alu_op respectively, assert rd_uart for exactly that cycle, advance to next state.
REQ-018 With rx_empty=1 in a WAIT state: rd_uart=0, state held, operand registers unchanged.
REQ-019 rd_uart SHALL never assert while rx_empty=1, nor in EXEC or SEND; rx bytes arriving then remain queued in the FIFO.
REQ-020 At most one byte popped per cycle; no two consecutive-cycle rd_uart pulses within a frame need be suppressed (back-to-back pops allowed).
REQ-021 EXEC lasts exactly one cycle: alu_result sampled into w_data register at its end; next state SEND.
REQ-022 In SEND with tx_full=0: wr_uart=1 for one cycle, then WAIT_A; with tx_full=1: wr_uart=0, hold SEND, w_data stable.
REQ-023 Minimum latency: wr_uart asserts 2 cycles after the rd_uart cycle that popped the opcode byte.
REQ-024 alu_a, alu_b, alu_op SHALL hold their values from capture until overwritten by the next frame.
REQ-025 Frames SHALL be processed strictly in order; exactly one result byte per three received bytes.

Reset
REQ-026 reset=0 SHALL immediately force state WAIT_A and rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, timeout_err, timeout counter to 0.
REQ-027 Reset mid-frame or during SEND discards partial operands and any pending result; no wr_uart after release until a full new frame.

Configuration
REQ-028 Macro UART_IF_TIMEOUT_EN defined: counter clears on every rd_uart and on entry to WAIT_A, increments each cycle in WAIT_B/WAIT_OP; on reaching TIMEOUT_CYCLES-1 FSM returns to WAIT_A and pulses timeout_err one cycle; a byte available in that same cycle is not popped.
REQ-029 Macro undefined: no counter logic, WAIT states wait indefinitely, timeout_err tied 0.

Verification
REQ-030 Bytes 0x05,0x03,0x20 with ALU model 0x20=ADD -> alu_a=0x05, alu_b=0x03, alu_op=0x20, single wr_uart with w_data=0x08 two cycles after third pop.
REQ-031 Same frame, tx_full held 1 for 10 cycles in SEND -> wr_uart low throughout, then exactly one pulse with w_data=0x08.
REQ-032 Six bytes queued (0x0A,0x02,0x22 SUB; 0xF0,0x0F,0x24 AND) -> two wr_uart pulses in order, 0x08 then 0x00; no pops during EXEC/SEND.
REQ-033 UART_IF_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte 0x11 only, idle 100 cycles -> timeout_err pulse, state WAIT_A; then 0x01,0x01,0x20 -> result 0x02.
REQ-034 reset=0 asserted after two bytes popped -> all outputs 0 asynchronously; after release, frame 0x02,0x02,0x20 -> single result 0x04.
